axis_dac_quantizer: RTL and testbench

Downstream stage of the 57 kHz FIR wrapper. It consumes the signed 64-bit FIR output stream and applies a programmable arithmetic right shift, a mid-scale offset and saturation to produce unsigned 8-bit DAC codes. It also decimates by a programmable ratio, carries tlast through, and counts clipped samples. It uses a 2-stage registered pipeline with full AXI-Stream backpressure.

---
 rtl/rds_dsp_pkg.sv | 16 +
 rtl/sat_quantize.sv | 23 ++
 rtl/axis_dac_quantizer.sv | 67 ++++++
 tb/tb_axis_dac_quantizer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rds_dsp_pkg.sv
// rds_dsp_pkg: shared widths and scaling constants for the RDS DSP output path
package rds_dsp_pkg;
  localparam int IN_WIDTH_D = 64;
  localparam int OUT_WIDTH_D = 8;
  localparam int DECIM_WIDTH_D = 8;
  localparam int CNT_WIDTH_D = 16;
  localparam int SHIFT_DEF = 24;
  function automatic longint out_mid(input int w);
    return longint'(1) << (w - 1);
  endfunction
  function automatic longint out_max(input int w);
    return (longint'(1) << w) - 1;
  endfunction
  localparam longint OUT_MID = out_mid(OUT_WIDTH_D);
  localparam longint OUT_MAX = out_max(OUT_WIDTH_D);
endpackage

// File: rtl/sat_quantize.sv
// sat_quantize: arithmetic shift, mid-scale offset and clamp to an unsigned code
module sat_quantize
  import rds_dsp_pkg::*;
#(
  parameter int IN_WIDTH = IN_WIDTH_D,
  parameter int OUT_WIDTH = OUT_WIDTH_D
) (
  input  logic [IN_WIDTH-1:0]  data,
  input  logic [5:0]           shift,
  output logic [OUT_WIDTH-1:0] code,
  output logic                 clip
);
  localparam logic signed [IN_WIDTH:0] MID = (IN_WIDTH+1)'(out_mid(OUT_WIDTH));
  localparam logic signed [IN_WIDTH:0] MAX = (IN_WIDTH+1)'(out_max(OUT_WIDTH));
  logic signed [IN_WIDTH:0] r;
  logic lo, hi;
  // one guard bit keeps the offset add from wrapping at full-scale inputs
  assign r = ($signed({data[IN_WIDTH-1], data}) >>> shift) + MID;
  assign lo = r < 0;
  assign hi = r > MAX;
  assign clip = lo | hi;
  assign code = lo ? '0 : hi ? '1 : r[OUT_WIDTH-1:0];
endmodule

// File: rtl/axis_dac_quantizer.sv
// axis_dac_quantizer: FIR stream to 8-bit DAC codes with decimation, tlast carry and clip count
module axis_dac_quantizer
  import rds_dsp_pkg::*;
#(
  parameter int IN_WIDTH = IN_WIDTH_D,
  parameter int OUT_WIDTH = OUT_WIDTH_D,
  parameter int DECIM_WIDTH = DECIM_WIDTH_D,
  parameter int CNT_WIDTH = CNT_WIDTH_D
) (
  input  logic                   s00_axis_aclk,
  input  logic                   s00_axis_areset,
  input  logic [IN_WIDTH-1:0]    s00_axis_tdata,
  input  logic                   s00_axis_tvalid,
  input  logic                   s00_axis_tlast,
  output logic                   s00_axis_tready,
  output logic [OUT_WIDTH-1:0]   m00_axis_tdata,
  output logic                   m00_axis_tvalid,
  output logic                   m00_axis_tlast,
  input  logic                   m00_axis_tready,
  input  logic [5:0]             shift,
  input  logic [DECIM_WIDTH-1:0] decim,
  output logic [CNT_WIDTH-1:0]   sat_count
);
  logic en, acc, keep, clip, s1_valid, s1_last, pend;
  logic [IN_WIDTH-1:0] s1_data;
  logic [5:0] s1_shift;
  logic [DECIM_WIDTH-1:0] dcnt, dlim;
  logic [OUT_WIDTH-1:0] code;
  assign en = !(m00_axis_tvalid && !m00_axis_tready);
  assign s00_axis_tready = en;
  assign acc = s00_axis_tvalid && en;
  assign keep = dcnt == '0;
  assign dlim = decim == '0 ? '0 : decim - 1'b1;
  sat_quantize #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_sq (
    .data(s1_data), .shift(s1_shift), .code(code), .clip(clip)
  );
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      s1_valid <= 1'b0;
      s1_last <= 1'b0;
      s1_data <= '0;
      s1_shift <= '0;
      dcnt <= '0;
      pend <= 1'b0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata <= '0;
      m00_axis_tlast <= 1'b0;
      sat_count <= '0;
    end else if (en) begin
      s1_valid <= acc && keep;
      if (acc) begin
        // >= rather than == so a ratio lowered mid-count still wraps
        dcnt <= (s00_axis_tlast || dcnt >= dlim) ? '0 : dcnt + 1'b1;
        pend <= keep ? 1'b0 : pend | s00_axis_tlast;
        s1_data <= s00_axis_tdata;
        s1_shift <= shift;
        s1_last <= s00_axis_tlast | pend;
      end
      m00_axis_tvalid <= s1_valid;
      if (s1_valid) begin
        m00_axis_tdata <= code;
        m00_axis_tlast <= s1_last;
        if (clip && sat_count != '1) sat_count <= sat_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axis_dac_quantizer.sv
// tb_axis_dac_quantizer: directed and randomized checks against a queue-based reference model
module tb_axis_dac_quantizer;
  logic clk = 0, rst = 1;
  logic [63:0] s_data = '0;
  logic s_valid = 0, s_last = 0, s_tready;
  logic [7:0] m_data;
  logic m_valid, m_last, m_ready = 1;
  logic [5:0] s_shift = '0;
  logic [7:0] s_decim = 8'd1;
  logic [15:0] sat_count;
  int n_vec = 0, n_err = 0, n_acc = 0, n_out = 0, n_stall = 0;
  int clipped = 0, kcnt = 0, rdy_mode = 0, sh = 0, dc = 1;
  bit pend = 0, acc = 0, prev_stall = 0;
  logic [7:0] hold_d, tl_data;
  logic hold_l;
  logic [8:0] q[$];

  axis_dac_quantizer dut (
    .s00_axis_aclk(clk), .s00_axis_areset(rst),
    .s00_axis_tdata(s_data), .s00_axis_tvalid(s_valid), .s00_axis_tlast(s_last),
    .s00_axis_tready(s_tready),
    .m00_axis_tdata(m_data), .m00_axis_tvalid(m_valid), .m00_axis_tlast(m_last),
    .m00_axis_tready(m_ready),
    .shift(s_shift), .decim(s_decim), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // floor(x / 2^sh) + 128, clamped to 0..255
  function automatic logic [7:0] ref_code(input logic [63:0] d, input int sh_amt, output bit cl);
    logic signed [71:0] x, p, v;
    x = 72'($signed(d));
    p = 72'sd1 <<< sh_amt;
    v = x / p;
    if (x < 0 && v * p != x) v = v - 1;
    v = v + 128;
    cl = (v < 0) || (v > 255);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  function automatic logic [63:0] rnd_data();
    logic [31:0] a, b;
    int s;
    a = $urandom;
    b = $urandom;
    s = int'($urandom_range(0, 600)) - 300;
    case ($urandom % 3)
      0: return {{32{a[31]}}, a};
      1: return {a, b};
      default: return 64'($signed(s));
    endcase
  endfunction

  always @(negedge clk) begin
    m_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 2 ? 1'b0 : ($urandom % 4 != 0);
  end

  always begin
    @(negedge clk);
    #4;
    if (rst) begin
      acc = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, hold_d);
        chk("hold_last", m_last, hold_l);
      end
      chk("tready", s_tready, !(m_valid && !m_ready));
      if (!s_tready) n_stall++;
      acc = s_valid && s_tready;
      if (acc) begin
        int d;
        bit cl;
        logic [7:0] ec;
        n_acc++;
        d = (s_decim == 0) ? 1 : int'(s_decim);
        if (kcnt % d == 0) begin
          ec = ref_code(s_data, int'(s_shift), cl);
          q.push_back({s_last | pend, ec});
          if (cl) clipped++;
          pend = 0;
        end else pend = pend | s_last;
        kcnt = s_last ? 0 : kcnt + 1;
      end
      if (m_valid && m_ready) begin
        n_out++;
        if (q.size() == 0) chk("spurious_out", q.size(), 1);
        else begin
          logic [8:0] e;
          e = q.pop_front();
          chk("data", m_data, e[7:0]);
          chk("last", m_last, e[8]);
        end
        if (m_last) tl_data = m_data;
      end
      prev_stall = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
    end
  end

  task automatic send(input logic [63:0] d, input logic l);
    int b;
    @(negedge clk);
    s_data = d;
    s_last = l;
    s_shift = 6'(sh);
    s_decim = 8'(dc);
    s_valid = 1;
    b = 0;
    do begin
      @(posedge clk);
      b++;
    end while (!acc && b < 300);
    if (!acc) chk("accept_timeout", acc, 1);
    #1 s_valid = 0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((q.size() != 0 || m_valid) && b < 500) begin
      @(negedge clk);
      b++;
    end
    if (b >= 500) chk("drain_timeout", q.size(), 0);
    repeat (2) @(negedge clk);
    chk("sat_count", sat_count, 16'(clipped));
  endtask

  task automatic do_reset(input bit expect_inflight);
    s_valid = 0;
    @(negedge clk);
    #2;
    if (expect_inflight) chk("pre_reset_valid", m_valid, 1);
    rst = 1;
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_sat", sat_count, 0);
    q.delete();
    kcnt = 0;
    pend = 0;
    clipped = 0;
    @(negedge clk);
    #2 rst = 0;
  endtask

  initial begin
    int a0, o0, s0;
    repeat (2) @(negedge clk);
    chk("reset_valid", m_valid, 0);
    chk("reset_data", m_data, 0);
    chk("reset_last", m_last, 0);
    chk("reset_sat", sat_count, 0);
    rst = 0;
    #1 chk("reset_tready", s_tready, 1);

    sh = 12; dc = 1;
    send(64'd4096, 0);
    chk("lat_early", m_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_valid", m_valid, 1);
    chk("lat_data", m_data, 129);
    send(64'($signed(-1048576)), 0);
    send(64'd1 << 30, 0);
    drain();
    chk("sat_two", sat_count, 2);

    do_reset(0);
    sh = 0; dc = 4;
    a0 = n_acc; o0 = n_out;
    for (int i = 0; i < 8; i++) send(64'(i), 0);
    drain();
    chk("dec_accepted", n_acc - a0, 8);
    chk("dec_outputs", n_out - o0, 2);

    do_reset(0);
    dc = 0;
    send(64'd5, 0);
    send(64'($signed(-5)), 0);
    drain();

    do_reset(0);
    dc = 4;
    o0 = n_out;
    for (int i = 0; i < 8; i++) send(64'(i), i == 2);
    drain();
    chk("tl_outputs", n_out - o0, 3);
    chk("tl_data", tl_data, 131);

    do_reset(0);
    dc = 1;
    s0 = n_stall;
    fork
      for (int i = 0; i < 16; i++) send(64'(i * 3 - 20), 0);
      begin
        repeat (2) @(negedge clk);
        rdy_mode = 2;
        repeat (10) @(negedge clk);
        rdy_mode = 0;
      end
    join
    drain();
    chk("bp_stalled", (n_stall - s0) >= 8, 1);

    do_reset(0);
    dc = 1 + int'($urandom % 5);
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      sh = int'($urandom % 64);
      if ($urandom % 4 == 0) sh = int'($urandom % 4);
      send(rnd_data(), ($urandom % 8) == 0);
      if ($urandom % 6 == 0) repeat ($urandom % 3) @(negedge clk);
    end
    drain();

    rdy_mode = 0;
    dc = 1; sh = 0;
    send(64'd1 << 40, 0);
    send(64'd1 << 41, 0);
    do_reset(1);
    send(64'd7, 0);
    send(64'd9, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
